// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - load/store request and response bundle for dmem_ctrl
interface dmem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressable little-endian RV32 data memory with configurable read latency
module dmem_ctrl #(
    parameter int DEPTH_BYTES  = 16384,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst,
    dmem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int EXT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [7:0]  mem_q [DEPTH_BYTES];

    logic [2:0]       nbytes;
    logic             size_bad;
    logic             misaligned;
    logic             out_of_range;
    logic             req_err;
    logic             accept;
    logic             mem_we;
    logic [EXT_W-1:0] end_addr;
    logic [IDX_W-1:0] base_idx;
    logic [31:0]      rd_word;
    logic [31:0]      ld_ext;

    always_comb begin
        nbytes = 3'd4;
        case (bus.req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // One extra bit so the end address of an access at the top of the space cannot wrap.
    assign end_addr     = {1'b0, bus.req_addr} + EXT_W'(nbytes);
    assign out_of_range = end_addr > EXT_W'(DEPTH_BYTES);
    assign size_bad     = (bus.req_size == 2'b11);
    assign req_err      = size_bad || misaligned || out_of_range;

    assign accept   = bus.req_valid && (state_q == ST_IDLE);
    assign mem_we   = accept && bus.req_we && !req_err && !rst;
    assign base_idx = bus.req_addr[IDX_W-1:0];

    // Upper byte indices may wrap for short accesses near the top; those bytes are discarded.
    assign rd_word = {mem_q[base_idx + IDX_W'(3)], mem_q[base_idx + IDX_W'(2)],
                      mem_q[base_idx + IDX_W'(1)], mem_q[base_idx]};

    always_comb begin
        ld_ext = rd_word;
        case (bus.req_size)
            2'b00:   ld_ext = bus.req_unsigned ? {24'h0, rd_word[7:0]}
                                               : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   ld_ext = bus.req_unsigned ? {16'h0, rd_word[15:0]}
                                               : {{16{rd_word[15]}}, rd_word[15:0]};
            default: ld_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes) begin
                    mem_q[base_idx + IDX_W'(k)] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.req_we) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else if (READ_LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_ext;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 2'(READ_LATENCY - 1);
                        hold_d  = ld_ext;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d     = ST_RESP;
                    cnt_d       = 2'd0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hold_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            hold_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised byte-addressable, little-endian data memory for the RV32 load/store stage, with a valid/ready request channel and a one-shot response channel. It supports byte/half/word stores and signed/unsigned loads with correct sign or zero extension, a configurable read latency, and misaligned and out-of-range access detection. It sits between the execute stage's load/store unit and the writeback mux and replaces the fixed 2 KiB memory.

## Interface
- DEPTH_BYTES, 16384: memory size in bytes; a power of two, at least 4.
- ADDR_W, 16: request address width; 2^ADDR_W is at least DEPTH_BYTES.
- READ_LATENCY, 1: number of cycles from load accept to response, legal range 1..4.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, taken from the low bytes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request; qualified by rsp_valid.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: load latency countdown.
  - RESP: rsp_valid=1.
- A request is accepted on a clock edge where req_valid && req_ready.
- Error check at accept. The request is an error if any of the following holds:
  - req_size==11.
  - Half access with addr[0]!=0.
  - Word access with addr[1:0]!=0.
  - addr + bytes(size) > DEPTH_BYTES.
- Error requests:
  - No memory write.
  - IDLE→RESP, with rsp_err=1 and rsp_rdata=0.
- Store, no error:
  - Bytes written at the accept edge. Byte k of req_wdata goes to addr+k, for k < bytes(size).
  - IDLE→RESP, with rsp_err=0 and rsp_rdata=0.
- Load, no error:
  - Raw bytes captured at the accept edge.
  - If READ_LATENCY==1: IDLE→RESP.
  - Otherwise: IDLE→WAIT with counter = READ_LATENCY−1. The counter decrements each cycle, and the FSM goes WAIT→RESP on the edge where it equals 1.
- RESP→IDLE unconditionally on the next edge. There is no back-pressure on the response.
- Load extension:
  - Byte: bit 7 is replicated into bits [31:8], or zero-filled when req_unsigned=1.
  - Half: bit 15 is replicated into bits [31:16], or zero-filled.
  - Word: passed through unchanged; req_unsigned is ignored.
- Only one request is outstanding at a time. req_ready=0 in WAIT and RESP.
- Reset:
  - Takes effect on any edge with rst=1: state←IDLE, counter←0, rsp_valid←0, rsp_rdata←0, rsp_err←0.
  - Memory contents are not cleared.
  - A request presented on a reset edge is not accepted and writes nothing.
- Reset mid-operation: a pending load is dropped with no response. A store already committed stays written.
- Memory contents are undefined until first written; the bench must initialise before reading.

## Timing
- Accept at edge E.
- Store and error cases: rsp_valid is high in the cycle after E. req_ready returns high 2 cycles after E, so back-to-back throughput is one request per 2 cycles.
- Loads: rsp_valid is high in the cycle following edge E+READ_LATENCY−1. req_ready returns one cycle after that.
- Read-after-write: a load accepted after a store to the same bytes returns the new data. The store commits at its own accept edge, which is strictly earlier.
- All outputs are registered. There is no combinational path from req_* to rsp_*. req_ready depends only on state.

## Test plan
- Word store then load, READ_LATENCY=1: store 0xDEADBEEF to 0x0100, then lw at 0x0100 → rsp_rdata=0xDEADBEEF, rsp_err=0. Byte loads at 0x0100..0x0103 return EF, BE, AD, DE, confirming little-endian order.
- Extension: store byte 0x80 to 0x0010. lb returns 0xFFFFFF80 and lbu returns 0x00000080. Store half 0x8001 to 0x0020. lh returns 0xFFFF8001 and lhu returns 0x00008001.
- Errors:
  - lh at 0x0003 → rsp_err=1, rsp_rdata=0.
  - sw of 0x12345678 at 0x0102 → rsp_err=1, and a later lw at 0x0100 still returns 0xDEADBEEF.
  - lw at DEPTH_BYTES−2 → rsp_err=1.
  - req_size=11 → rsp_err=1.
- Latency: with READ_LATENCY=3, a load accepted at edge 0 gives rsp_valid in cycle 3 only, and req_ready is 0 in cycles 1–3. A req_valid held during those cycles is accepted at edge 4.
- Reset mid-load: with READ_LATENCY=4, assert rst one cycle after accept → no rsp_valid ever for that load, and req_ready=1 in the cycle after reset. A prior store's data remains readable.
